// File: rtl/regfile_sb_pkg.sv
// Shared MIPS register-file constants: default widths and the hard-wired zero register.
package regfile_sb_pkg;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_ADDR_W = 5;
  localparam int REG_ZERO    = 0;

endpackage

// File: rtl/regfile_sb_bypass.sv
// One read port: zero-register forcing, write-to-read bypass and load-pending masking.
module regfile_sb_bypass
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = MIPS_DATA_W,
  parameter int ADDR_W = MIPS_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              arr_busy,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  logic is_zero;
  logic wr0_hit;
  logic wr1_hit;

  assign is_zero = (addr == ADDR_W'(REG_ZERO));
  assign wr0_hit = wr0_en && (wr0_addr == addr);
  assign wr1_hit = wr1_en && (wr1_addr == addr);

  // The ALU write is the younger instruction, so it outranks a completing load.
  always_comb begin
    data = arr_data;
    if (is_zero)      data = '0;
    else if (wr0_hit) data = wr0_data;
    else if (wr1_hit) data = wr1_data;
  end

  assign busy = arr_busy && !wr1_hit && !is_zero;

endmodule

// File: rtl/regfile_sb.sv
// Clocked MIPS register file with two writeback ports, NUM_RD bypassed read ports
// and a per-register load scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = MIPS_DATA_W,
  parameter int ADDR_W = MIPS_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;

  // wr0 is applied last so it wins a same-address collision with wr1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
    end else begin
      if (wr1_en && (wr1_addr != ADDR_W'(REG_ZERO))) mem[wr1_addr] <= wr1_data;
      if (wr0_en && (wr0_addr != ADDR_W'(REG_ZERO))) mem[wr0_addr] <= wr0_data;
    end
  end

  // A new issue outranks a completing load so back-to-back loads stay pending.
  always_comb begin
    busy_next = busy;
    if (wr1_en) busy_next[wr1_addr] = 1'b0;
    if (issue_en) busy_next[issue_addr] = 1'b1;
    busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] port_addr;
    assign port_addr = rd_addr[i*ADDR_W +: ADDR_W];

    regfile_sb_bypass #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_bypass (
      .addr    (port_addr),
      .wr0_en  (wr0_en),
      .wr0_addr(wr0_addr),
      .wr0_data(wr0_data),
      .wr1_en  (wr1_en),
      .wr1_addr(wr1_addr),
      .wr1_data(wr1_data),
      .arr_data(mem[port_addr]),
      .arr_busy(busy[port_addr]),
      .data    (rd_data[i*DATA_W +: DATA_W]),
      .busy    (rd_busy[i])
    );
  end

endmodule
